// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared fetch-side types: address width, PC type and the fetch/decode entry.
// Also used by the decode side, which is why fd_entry_t lives here.
package instruction_fetch_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fd_entry_t;

endpackage

// File: rtl/fetch_inflight_tracker.sv
// Tracks fetches between issue and data return as a LOAD_LATENCY-deep valid
// shift register; the last stage marks the cycle the memory word arrives.
module fetch_inflight_tracker #(
    parameter int LOAD_LATENCY = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue,
    input  logic                                flush,
    output logic                                arrive,
    output logic [$clog2(LOAD_LATENCY+1)-1:0]   inflight
);

    localparam int CNT_W = $clog2(LOAD_LATENCY + 1);

    logic [LOAD_LATENCY-1:0] vld_pipe_q;
    logic [LOAD_LATENCY-1:0] vld_pipe_d;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = issue;
        for (int i = 1; i < LOAD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign arrive = vld_pipe_q[LOAD_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
    end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch-to-decode buffer: circular FIFO of {pc, inst} fed by instruction memory,
// with issue throttled so in-flight returns always find a free slot.
module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  addr_t                    pc_to_fet,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     flush,
    output logic                     stall_pc,
    output logic                     fd_valid,
    input  logic                     fd_ready,
    output addr_t                    fd_pc,
    output logic [DATA_W-1:0]        fd_inst,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int INF_W = $clog2(LOAD_LATENCY + 1);
    localparam int SUM_W = OCC_W + 1;

    addr_t             pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q,  occ_d;

    logic              issue;
    logic              arrive;
    logic              arrive_w;
    logic              pop;
    logic [INF_W-1:0]  inflight;

    fetch_inflight_tracker #(
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .flush    (flush),
        .arrive   (arrive),
        .inflight (inflight)
    );

    // Reserve a slot for every outstanding fetch; only registered state feeds this.
    assign stall_pc = (SUM_W'(occ_q) + SUM_W'(inflight)) >= SUM_W'(DEPTH);
    assign issue    = !stall_pc && !flush;

    assign fd_valid  = (occ_q != '0);
    assign fd_pc     = pc_q[head_q];
    assign fd_inst   = inst_q[head_q];
    assign occupancy = occ_q;

    assign arrive_w = arrive && !flush;
    assign pop      = fd_valid && fd_ready && !flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (arrive_w) begin
            tail_d = tail_q + 1'b1;
        end
        case ({arrive_w, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (arrive_w) begin
                pc_q[tail_q]   <= pc_to_fet;
                inst_q[tail_q] <= mem_data;
            end
        end
    end

    // The stall rule makes this unreachable; firing means the throttle is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(arrive_w && occ_q == OCC_W'(DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Scoreboard bench: instance A (LAT=2, DEPTH=4) for fill/stall/flush/wrap/reset,
// instance B (LAT=1) for first-fetch latency and streaming pairing.
module tb_instruction_fetch_buffer;
    import instruction_fetch_buffer_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst, flush, rdy_a, rdy_b;
    addr_t pc_a, pc_b, fdpc_a, fdpc_b;
    logic [DW-1:0] md_a, md_b, inst_a, inst_b;
    logic stall_a, stall_b, vld_a, vld_b;
    logic [$clog2(DEPTH):0] occ_a, occ_b;

    always #5 clk = ~clk;

    instruction_fetch_buffer #(.LOAD_LATENCY(LAT), .DEPTH(DEPTH), .DATA_W(DW)) dut_a (
        .clk(clk), .rst(rst), .pc_to_fet(pc_a), .mem_data(md_a), .flush(flush),
        .stall_pc(stall_a), .fd_valid(vld_a), .fd_ready(rdy_a), .fd_pc(fdpc_a),
        .fd_inst(inst_a), .occupancy(occ_a));

    instruction_fetch_buffer #(.LOAD_LATENCY(1), .DEPTH(DEPTH), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst), .pc_to_fet(pc_b), .mem_data(md_b), .flush(flush),
        .stall_pc(stall_b), .fd_valid(vld_b), .fd_ready(rdy_b), .fd_pc(fdpc_b),
        .fd_inst(inst_b), .occupancy(occ_b));

    int errs = 0;
    int checks = 0;
    int pops_a = 0;

    addr_t sb_q[$];
    logic  pv [LAT];
    addr_t ppc[LAT];
    addr_t npc_a = 32'h1000;
    addr_t npc_b = 32'h8000;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One clock: check current outputs against the model, clock, advance the model.
    task automatic step();
        logic iss, arr, pop, iss_b, exp_stall;
        int infl;
        #1;
        infl = 0;
        for (int i = 0; i < LAT; i++) infl += int'(pv[i]);
        exp_stall = (sb_q.size() + infl) >= DEPTH;
        chk("occ", 64'(occ_a), 64'(sb_q.size()));
        chk("fd_valid", 64'(vld_a), 64'(sb_q.size() != 0));
        chk("stall", 64'(stall_a), 64'(exp_stall));
        iss = !exp_stall && !flush && !rst;
        arr = pv[LAT-1] && !flush && !rst;
        pop = (sb_q.size() != 0) && rdy_a && !flush && !rst;
        if (pop) begin
            chk("fd_pc", 64'(fdpc_a), 64'(sb_q[0]));
            chk("fd_inst", 64'(inst_a), 64'(sb_q[0] + 32'h100));
        end
        chk("b_stall", 64'(stall_b), 64'(0));
        if (vld_b) chk("b_inst", 64'(inst_b), 64'(fdpc_b + 32'h100));
        iss_b = !stall_b && !flush && !rst;

        @(posedge clk);
        #1;
        if (rst || flush) begin
            sb_q.delete();
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end else begin
            if (pop) begin
                void'(sb_q.pop_front());
                pops_a++;
            end
            if (arr) sb_q.push_back(ppc[LAT-1]);
            for (int i = LAT-1; i > 0; i--) begin
                pv[i]  = pv[i-1];
                ppc[i] = ppc[i-1];
            end
            pv[0]  = iss;
            ppc[0] = npc_a;
            if (iss) npc_a += 32'd4;
        end
        pc_a = ppc[LAT-1];
        md_a = ppc[LAT-1] + 32'h100;
        if (iss_b) begin
            pc_b  = npc_b;
            md_b  = npc_b + 32'h100;
            npc_b += 32'd4;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_occ"},   64'(occ_a),   64'(0));
        chk({tag, "_vld"},   64'(vld_a),   64'(0));
        chk({tag, "_pc"},    64'(fdpc_a),  64'(0));
        chk({tag, "_inst"},  64'(inst_a),  64'(0));
        chk({tag, "_stall"}, 64'(stall_a), 64'(0));
        chk({tag, "_bvld"},  64'(vld_b),   64'(0));
        chk({tag, "_bpc"},   64'(fdpc_b),  64'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        pc_a = '0; md_a = '0; pc_b = '0; md_b = '0;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; ppc[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outs("rst");

        // LAT=1 instance: first word visible two cycles after reset release
        step();
        chk("b_vld_c1", 64'(vld_b), 64'(0));
        step();
        chk("b_vld_c2", 64'(vld_b), 64'(1));
        chk("b_first_pc", 64'(fdpc_b), 64'(32'h8000));

        // Streaming with decode always ready
        repeat (10) step();

        // Fill with decode blocked
        rdy_a = 1'b0;
        repeat (8) step();
        chk("full_occ", 64'(occ_a), 64'(4));
        chk("full_stall", 64'(stall_a), 64'(1));

        // Single pop from full: stall clears, one issue refills
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        chk("pop_occ", 64'(occ_a), 64'(3));
        chk("pop_stall", 64'(stall_a), 64'(0));
        step();
        chk("refill_stall", 64'(stall_a), 64'(1));
        repeat (2) step();
        chk("refill_occ", 64'(occ_a), 64'(4));

        // Flush with occupancy 3 and one fetch in flight
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        step();
        chk("pre_flush_occ", 64'(occ_a), 64'(3));
        chk("pre_flush_stall", 64'(stall_a), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_occ", 64'(occ_a), 64'(0));
        chk("flush_vld", 64'(vld_a), 64'(0));

        // Sustained pop: pointers wrap several times, scoreboard checks order
        rdy_a = 1'b1;
        pops_a = 0;
        repeat (24) step();
        chk("wrap_pops", 64'(pops_a > 2*DEPTH), 64'(1));

        // Reset with flush while two entries are held
        rdy_a = 1'b0;
        n = 0;
        while (occ_a != 2 && n < 12) begin step(); n++; end
        chk("occ_reach_2", 64'(occ_a), 64'(2));
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        chk_reset_outs("midrst");

        // Random ready / occasional flush
        for (int k = 0; k < 80; k++) begin
            rdy_a = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        rdy_a = 1'b1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_buffer.md
INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

Interface
REQ-001 Parameter LOAD_LATENCY, default 1: cycles from instruction-memory request to mem_data valid; legal range 1..4.
REQ-002 Parameter DEPTH, default 4: buffer entries; power of two, >= LOAD_LATENCY+1.
REQ-003 Parameter DATA_W, default 32: instruction word width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pc_to_fet  input  ADDR_W (addr_t)  PC paired with the word currently on mem_data.
REQ-007 mem_data  input  DATA_W  instruction-memory read data, valid LOAD_LATENCY cycles after an issued request.
REQ-008 flush  input  1  discard buffered and in-flight fetches.
REQ-009 stall_pc  output  1  request-side hold; when 1, no new fetch is issued this cycle.
REQ-010 fd_valid  output  1  head entry valid toward decode.
REQ-011 fd_ready  input  1  decode accepts head entry.
REQ-012 fd_pc  output  ADDR_W  PC of head entry.
REQ-013 fd_inst  output  DATA_W  instruction word of head entry.
REQ-014 occupancy  output  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-015 An issue occurs in every cycle where stall_pc=0 and flush=0.
REQ-016 Issues are tracked in a LOAD_LATENCY-stage valid shift register; stage 0 loads the issue bit each cycle.
REQ-017 An arrival occurs when the last stage is 1; on arrival {pc_to_fet, mem_data} is written at the tail in that cycle.
REQ-018 inflight = number of 1s in the shift register, 0..LOAD_LATENCY.
REQ-019 stall_pc = 1 when occupancy + inflight >= DEPTH; combinational from registered state only, never from fd_ready.
REQ-020 REQ-019 guarantees an arrival never meets a full buffer; an arrival at full is a design error and shall be flagged by assertion.
REQ-021 fd_valid = (occupancy != 0); fd_pc/fd_inst show the head entry with zero-cycle latency.
REQ-022 Pop on fd_valid & fd_ready; the head advances next cycle.
REQ-023 Simultaneous pop and arrival: occupancy unchanged; both take effect.
REQ-024 An arrival into an empty buffer becomes visible on fd_valid the following cycle; the buffer provides no bypass.
REQ-025 Head and tail pointers wrap modulo DEPTH.
REQ-026 When flush=1: next cycle occupancy=0 and all shift-register stages=0.
REQ-027 When flush=1, any same-cycle arrival and pop are ignored, and no issue occurs that cycle.
REQ-028 fd_ready while fd_valid=0 has no effect.
REQ-029 fd_pc/fd_inst are don't-care when fd_valid=0 but shall not be X after reset.

Reset
REQ-030 When rst=1 at a clock edge: occupancy=0, pointers=0, shift register=0, stored entries=0.
REQ-031 After reset, fd_valid=0, fd_pc=0, fd_inst=0, and stall_pc=0 in the first cycle after rst deasserts.
REQ-032 rst mid-operation discards all entries and in-flight requests; rst overrides flush.

Structure
REQ-033 addr_t, ADDR_W and a new fd_entry_t {addr_t pc; inst word} shall live in the shared common parameters package.
REQ-034 The inflight shift register shall be one sub-module, fetch_inflight_tracker (ports: clk, rst, issue, flush, arrive, inflight).
REQ-035 FIFO storage, pointers and stall logic stay in instruction_fetch_buffer.

Verification
REQ-036 Reset, then issue with fd_ready=1, LOAD_LATENCY=1, memory returning pc+0x100 -> fd_valid at cycle 2; fd_inst = fd_pc+0x100 every cycle; stall_pc never 1.
REQ-037 DEPTH=4, LOAD_LATENCY=2, fd_ready=0 -> stall_pc rises when occupancy+inflight=4; occupancy settles at exactly 4; no overflow assertion fires.
REQ-038 Full buffer, then fd_ready=1 for one cycle -> occupancy 4->3; stall_pc clears the same cycle; one new issue occurs; occupancy back to 4 after LOAD_LATENCY cycles.
REQ-039 flush pulsed with occupancy=3 and inflight=1 -> next cycle occupancy=0, fd_valid=0; the in-flight word is never presented.
REQ-040 Sustained pop with arrival each cycle over more than 2*DEPTH entries -> pointers wrap; fd_pc strictly in issue order with no gaps or duplicates.
REQ-041 rst asserted with occupancy=2 and flush=1 simultaneously -> all outputs at reset values next cycle.
